// File: rtl/tetris_key_ctrl.sv
// PS/2 scan-code sequencer for Tetris: make/break/E0 decode, held keys,
// DAS/ARR auto-repeat and a small command FIFO toward the game FSM.
module tetris_key_ctrl #(
  parameter int DAS_DELAY  = 15_000_000,
  parameter int ARR_PERIOD = 5_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [5:0] held,
  output logic       overflow
);

  localparam int CMAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int CW   = $clog2(CMAX);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;

  localparam logic [CW-1:0] DAS_LD = CW'(DAS_DELAY - 1);
  localparam logic [CW-1:0] ARR_LD = CW'(ARR_PERIOD - 1);
  localparam logic [NW-1:0] FULL   = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EBRK
  } st_t;

  st_t r_st;
  st_t w_st_nxt;

  logic          w_mk;
  logic          w_bk;
  logic          w_ext;
  logic          w_hit;
  logic [2:0]    w_key;
  logic          w_mk_hit;
  logic          w_bk_hit;
  logic          w_fresh;
  logic          w_rpt_ok;
  logic          w_brk_rep;
  logic          w_fire;
  logic          w_push;
  logic [2:0]    w_pdata;
  logic          w_pop;
  logic          w_full;
  logic          w_wr_en;

  logic [5:0]    r_held;
  logic          r_rep_on;
  logic [2:0]    r_rep_key;
  logic [CW-1:0] r_rep_cnt;

  logic [2:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [NW-1:0] r_cnt;
  logic          r_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_st <= S_IDLE;
    else     r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    if (valid) begin
      unique case (r_st)
        S_IDLE: begin
          if (data == 8'hE0)      w_st_nxt = S_EXT;
          else if (data == 8'hF0) w_st_nxt = S_BRK;
          else                    w_st_nxt = S_IDLE;
        end
        S_EXT:  w_st_nxt = (data == 8'hF0) ? S_EBRK : S_IDLE;
        S_BRK:  w_st_nxt = S_IDLE;
        S_EBRK: w_st_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_mk  = 1'b0;
    w_bk  = 1'b0;
    w_ext = 1'b0;
    if (valid) begin
      unique case (r_st)
        S_IDLE: w_mk = (data != 8'hE0) && (data != 8'hF0);
        S_EXT: begin
          w_mk  = (data != 8'hF0);
          w_ext = 1'b1;
        end
        S_BRK:  w_bk = 1'b1;
        S_EBRK: begin
          w_bk  = 1'b1;
          w_ext = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_hit = 1'b0;
    w_key = 3'd0;
    if (w_ext) begin
      case (data)
        8'h6B:   begin w_hit = 1'b1; w_key = 3'd0; end
        8'h74:   begin w_hit = 1'b1; w_key = 3'd1; end
        8'h72:   begin w_hit = 1'b1; w_key = 3'd2; end
        8'h75:   begin w_hit = 1'b1; w_key = 3'd3; end
        default: ;
      endcase
    end else begin
      case (data)
        8'h29:   begin w_hit = 1'b1; w_key = 3'd4; end
        8'h4D:   begin w_hit = 1'b1; w_key = 3'd5; end
        default: ;
      endcase
    end
  end

  assign w_mk_hit  = w_mk && w_hit;
  assign w_bk_hit  = w_bk && w_hit;
  assign w_fresh   = w_mk_hit && !r_held[w_key];
  assign w_rpt_ok  = (w_key <= 3'd2);
  assign w_brk_rep = w_bk_hit && r_rep_on && (w_key == r_rep_key);

  // A fresh make owns the push slot; a due repeat waits with its count at 0.
  assign w_fire  = r_rep_on && (r_rep_cnt == '0) && !w_brk_rep && !w_fresh;
  assign w_push  = w_fresh || w_fire;
  assign w_pdata = w_fresh ? w_key : r_rep_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held <= '0;
    end else if (w_fresh) begin
      r_held[w_key] <= 1'b1;
    end else if (w_bk_hit) begin
      r_held[w_key] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_on  <= 1'b0;
      r_rep_key <= 3'd0;
      r_rep_cnt <= '0;
    end else if (w_fresh && w_rpt_ok) begin
      r_rep_on  <= 1'b1;
      r_rep_key <= w_key;
      r_rep_cnt <= DAS_LD;
    end else if (w_brk_rep) begin
      r_rep_on <= 1'b0;
    end else if (r_rep_on) begin
      if (r_rep_cnt != '0) r_rep_cnt <= r_rep_cnt - 1'b1;
      else if (w_fire)     r_rep_cnt <= ARR_LD;
    end
  end

  assign w_pop   = (r_cnt != '0) && cmd_ready;
  assign w_full  = (r_cnt == FULL);
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 3'd0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr] <= w_pdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_wr_en && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr_en && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_push && !w_wr_en) r_ovf <= 1'b1;
    end
  end

  assign cmd       = r_mem[r_rd];
  assign cmd_valid = (r_cnt != '0);
  assign held      = r_held;
  assign overflow  = r_ovf;

endmodule
